// File: rtl/jtag_tap_debug.sv
// Debug TAP: 1149.1 controller, IR, and BYPASS/IDCODE/DEBUG/HALT_CTRL data registers for CPU debug.
// Latency: state, capture, shift and update on posedge tck; tdo/tdo_en registered on negedge tck.
// Backpressure: none, the external debugger paces everything through tck/tms.
module jtag_tap_debug #(
    parameter int          IR_WIDTH   = 4,
    parameter int          DR_WIDTH   = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1DA5_C001
) (
    input  logic                tck,
    input  logic                trst_n,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    input  logic                cpu_halted,
    output logic                halt_cpu,
    output logic [DR_WIDTH-1:0] debug_reg,
    output logic [3:0]          tap_state
);

    typedef enum logic [3:0] {
        TLR     = 4'd0,  RTI     = 4'd1,  SEL_DR  = 4'd2,  CAP_DR  = 4'd3,
        SH_DR   = 4'd4,  EX1_DR  = 4'd5,  PAU_DR  = 4'd6,  EX2_DR  = 4'd7,
        UPD_DR  = 4'd8,  SEL_IR  = 4'd9,  CAP_IR  = 4'd10, SH_IR   = 4'd11,
        EX1_IR  = 4'd12, PAU_IR  = 4'd13, EX2_IR  = 4'd14, UPD_IR  = 4'd15
    } tap_state_t;

    typedef enum logic [1:0] {SEL_BYP, SEL_ID, SEL_DBG, SEL_HALT} dr_sel_t;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_DEBUG  = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] IR_HALT   = IR_WIDTH'(3);

    tap_state_t          state;
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] ir_sr;
    logic                byp_sr;
    logic [31:0]         id_sr;
    logic [DR_WIDTH-1:0] dbg_sr;
    logic [1:0]          halt_sr;
    dr_sel_t             dr_sel;
    logic                dr_lsb;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic m);
        case (s)
            TLR:     return m ? TLR    : RTI;
            RTI:     return m ? SEL_DR : RTI;
            SEL_DR:  return m ? SEL_IR : CAP_DR;
            CAP_DR:  return m ? EX1_DR : SH_DR;
            SH_DR:   return m ? EX1_DR : SH_DR;
            EX1_DR:  return m ? UPD_DR : PAU_DR;
            PAU_DR:  return m ? EX2_DR : PAU_DR;
            EX2_DR:  return m ? UPD_DR : SH_DR;
            UPD_DR:  return m ? SEL_DR : RTI;
            SEL_IR:  return m ? TLR    : CAP_IR;
            CAP_IR:  return m ? EX1_IR : SH_IR;
            SH_IR:   return m ? EX1_IR : SH_IR;
            EX1_IR:  return m ? UPD_IR : PAU_IR;
            PAU_IR:  return m ? EX2_IR : PAU_IR;
            EX2_IR:  return m ? UPD_IR : SH_IR;
            UPD_IR:  return m ? SEL_DR : RTI;
            default: return TLR;
        endcase
    endfunction

    // Unassigned instruction codes fall back to BYPASS.
    always_comb begin
        dr_sel = SEL_BYP;
        if (ir == IR_IDCODE)     dr_sel = SEL_ID;
        else if (ir == IR_DEBUG) dr_sel = SEL_DBG;
        else if (ir == IR_HALT)  dr_sel = SEL_HALT;
    end

    always_comb begin
        dr_lsb = byp_sr;
        case (dr_sel)
            SEL_ID:   dr_lsb = id_sr[0];
            SEL_DBG:  dr_lsb = dbg_sr[0];
            SEL_HALT: dr_lsb = halt_sr[0];
            default:  dr_lsb = byp_sr;
        endcase
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state     <= TLR;
            ir        <= IR_IDCODE;
            ir_sr     <= '0;
            byp_sr    <= 1'b0;
            id_sr     <= '0;
            dbg_sr    <= '0;
            halt_sr   <= '0;
            debug_reg <= '0;
            halt_cpu  <= 1'b0;
        end else begin
            state <= tap_next(state, tms);
            // debug_reg and halt_cpu survive a TMS reset so the CPU stays halted.
            case (state)
                TLR:    ir    <= IR_IDCODE;
                CAP_IR: ir_sr <= IR_WIDTH'(1);
                SH_IR:  ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
                UPD_IR: ir    <= ir_sr;
                CAP_DR: begin
                    case (dr_sel)
                        SEL_ID:   id_sr   <= IDCODE_VAL;
                        SEL_DBG:  dbg_sr  <= debug_reg;
                        SEL_HALT: halt_sr <= {cpu_halted, halt_cpu};
                        default:  byp_sr  <= 1'b0;
                    endcase
                end
                SH_DR: begin
                    case (dr_sel)
                        SEL_ID:   id_sr   <= {tdi, id_sr[31:1]};
                        SEL_DBG:  dbg_sr  <= {tdi, dbg_sr[DR_WIDTH-1:1]};
                        SEL_HALT: halt_sr <= {tdi, halt_sr[1]};
                        default:  byp_sr  <= tdi;
                    endcase
                end
                UPD_DR: begin
                    if (dr_sel == SEL_DBG)  debug_reg <= dbg_sr;
                    if (dr_sel == SEL_HALT) halt_cpu  <= halt_sr[0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= (state == SH_IR) || (state == SH_DR);
            if (state == SH_IR)      tdo <= ir_sr[0];
            else if (state == SH_DR) tdo <= dr_lsb;
            else                     tdo <= 1'b0;
        end
    end

    assign tap_state = state;

endmodule

// File: tb/tb_jtag_tap_debug.sv
// Bench for jtag_tap_debug: directed scan table, hand-written corner sequences, and a random TMS/TDI walk
// checked every cycle against an integer-level TAP model.
module tb_jtag_tap_debug;

    localparam int          IRW = 4;
    localparam int          DRW = 8;
    localparam logic [31:0] IDV = 32'h1DA5_C001;

    logic           tck = 1'b0;
    logic           trst_n;
    logic           tms;
    logic           tdi;
    logic           tdo;
    logic           tdo_en;
    logic           cpu_halted;
    logic           halt_cpu;
    logic [DRW-1:0] debug_reg;
    logic [3:0]     tap_state;

    always #10 tck = ~tck;

    jtag_tap_debug #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .IDCODE_VAL(IDV)) dut (
        .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .cpu_halted(cpu_halted), .halt_cpu(halt_cpu), .debug_reg(debug_reg), .tap_state(tap_state)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain integers, a next-state table, and a single active DR value + width.
    int     nxt [16][2];
    int     m_state, m_ir, m_ir_sr, m_debug, m_halt, m_dw;
    longint m_dr;
    logic   last_tdo;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic int dr_width(input int code);
        case (code)
            1:       return 32;
            2:       return DRW;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic void model_reset();
        m_state = 0; m_ir = 1; m_ir_sr = 0; m_dr = 0; m_dw = 1; m_debug = 0; m_halt = 0;
    endfunction

    function automatic void model_advance(input logic t_ms, input logic t_di);
        case (m_state)
            10: m_ir_sr = 1;
            11: m_ir_sr = (m_ir_sr >> 1) | (int'(t_di) << (IRW - 1));
            15: m_ir = m_ir_sr;
            3: begin
                m_dw = dr_width(m_ir);
                if (m_ir == 1)      m_dr = longint'(IDV);
                else if (m_ir == 2) m_dr = longint'(m_debug);
                else if (m_ir == 3) m_dr = longint'(int'(cpu_halted) * 2 + m_halt);
                else                m_dr = 0;
            end
            4: m_dr = (m_dr >> 1) | (longint'(t_di) << (m_dw - 1));
            8: begin
                if (m_ir == 2)      m_debug = int'(m_dr);
                else if (m_ir == 3) m_halt  = int'(m_dr & 1);
            end
            default: ;
        endcase
        m_state = nxt[m_state][int'(t_ms)];
        if (m_state == 0) m_ir = 1;
    endfunction

    // One tck cycle: drive after negedge, check tdo for this cycle, check state/outputs after posedge.
    task automatic step(input logic t_ms, input logic t_di);
        logic exp_en, exp_tdo;
        @(negedge tck);
        #2;
        tms = t_ms;
        tdi = t_di;
        exp_en  = (m_state == 4) || (m_state == 11);
        exp_tdo = (m_state == 11) ? m_ir_sr[0] : (m_state == 4) ? m_dr[0] : 1'b0;
        chk("tdo", 32'(tdo), 32'(exp_tdo));
        chk("tdo_en", 32'(tdo_en), 32'(exp_en));
        last_tdo = tdo;
        model_advance(t_ms, t_di);
        @(posedge tck);
        #1;
        chk("tap_state", 32'(tap_state), 32'(m_state));
        chk("debug_reg", 32'(debug_reg), 32'(m_debug));
        chk("halt_cpu", 32'(halt_cpu), 32'(m_halt));
    endtask

    task automatic load_ir(input logic [IRW-1:0] code);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < IRW; i++) step(1'(i == IRW - 1), code[i]);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            step(1'(i == n - 1), din[i]);
            dout[i] = last_tdo;
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    typedef struct {
        logic [IRW-1:0] ir;
        int             n;
        logic [31:0]    din;
        logic           cpu_h;
        logic [31:0]    exp_out;
        logic [DRW-1:0] exp_dbg;
        logic           exp_halt;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [31:0] dout;
        logic [31:0] mask;

        nxt = '{'{1, 0}, '{1, 2}, '{3, 9}, '{4, 5}, '{4, 5}, '{6, 8}, '{6, 7}, '{4, 8},
                '{1, 2}, '{10, 0}, '{11, 12}, '{11, 12}, '{13, 15}, '{13, 14}, '{11, 15}, '{1, 2}};

        tbl[0] = '{4'h1, 32, 32'h0,   1'b0, 32'h1DA5_C001, 8'h00, 1'b0};
        tbl[1] = '{4'h2, 8,  32'hA5,  1'b0, 32'h00,        8'hA5, 1'b0};
        tbl[2] = '{4'h2, 8,  32'h00,  1'b0, 32'hA5,        8'h00, 1'b0};
        tbl[3] = '{4'h3, 2,  32'h1,   1'b0, 32'h0,         8'h00, 1'b1};
        tbl[4] = '{4'h3, 2,  32'h1,   1'b1, 32'h3,         8'h00, 1'b1};
        tbl[5] = '{4'hF, 4,  32'hD,   1'b1, 32'hA,         8'h00, 1'b1};
        tbl[6] = '{4'h7, 4,  32'hD,   1'b1, 32'hA,         8'h00, 1'b1};
        tbl[7] = '{4'h2, 8,  32'h3C,  1'b1, 32'h00,        8'h3C, 1'b1};
        tbl[8] = '{4'h2, 12, 32'hABC, 1'b1, 32'hC3C,       8'hAB, 1'b1};

        tms = 1'b0; tdi = 1'b0; cpu_halted = 1'b0; trst_n = 1'b0;
        model_reset();
        #13;
        chk("rst_state", 32'(tap_state), 32'd0);
        chk("rst_debug", 32'(debug_reg), 32'd0);
        chk("rst_halt", 32'(halt_cpu), 32'd0);
        chk("rst_tdo_en", 32'(tdo_en), 32'd0);
        #2 trst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("rti_after_reset", 32'(tap_state), 32'd1);

        // IDCODE is the default instruction: DR scan without IR load.
        scan_dr(32, 32'h0, dout);
        chk("idcode_default", dout, IDV);

        for (int v = 0; v < 9; v++) begin
            cpu_halted = tbl[v].cpu_h;
            load_ir(tbl[v].ir);
            scan_dr(tbl[v].n, tbl[v].din, dout);
            mask = (tbl[v].n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << tbl[v].n) - 32'd1);
            chk($sformatf("tbl%0d_out", v), dout & mask, tbl[v].exp_out);
            chk($sformatf("tbl%0d_dbg", v), 32'(debug_reg), 32'(tbl[v].exp_dbg));
            chk($sformatf("tbl%0d_halt", v), 32'(halt_cpu), 32'(tbl[v].exp_halt));
        end

        // TMS reset keeps halt_cpu/debug_reg but restores IDCODE.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("tms_tlr_state", 32'(tap_state), 32'd0);
        chk("tms_tlr_halt", 32'(halt_cpu), 32'd1);
        chk("tms_tlr_dbg", 32'(debug_reg), 32'hAB);
        step(1'b0, 1'b0);
        scan_dr(32, 32'h0, dout);
        chk("tms_tlr_idcode", dout, IDV);

        // Split DEBUG shift across Pause-DR, then commit.
        load_ir(4'h2);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        dout = '0;
        for (int i = 0; i < 4; i++) begin step(1'(i == 3), 1'(8'h5A >> i)); dout[i] = last_tdo; end
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        chk("pause_no_update", 32'(debug_reg), 32'hAB);
        for (int i = 4; i < 8; i++) begin step(1'(i == 7), 1'(8'h5A >> i)); dout[i] = last_tdo; end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        chk("pause_capture", dout, 32'hAB);
        chk("pause_update", 32'(debug_reg), 32'h5A);

        // Mid-shift trst_n aborts with no partial update.
        scan_dr(8, 32'h3C, dout);
        chk("abort_pre", 32'(debug_reg), 32'h3C);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        #3 trst_n = 1'b0;
        #1;
        chk("abort_state", 32'(tap_state), 32'd0);
        chk("abort_dbg", 32'(debug_reg), 32'd0);
        chk("abort_halt", 32'(halt_cpu), 32'd0);
        chk("abort_tdo_en", 32'(tdo_en), 32'd0);
        model_reset();
        #3 trst_n = 1'b1;

        // Random walks, with periodic random IR/DR scans to reach deep states.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            cpu_halted = 1'($urandom_range(0, 1));
            load_ir(IRW'($urandom_range(0, 15)));
            scan_dr(int'($urandom_range(1, 20)), $urandom, dout);
            for (int i = 0; i < 60; i++) begin
                cpu_halted = 1'($urandom_range(0, 1));
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jtag_tap_debug.md
Name: jtag_tap_debug

Overview:
- Parametrised IEEE 1149.1-style debug TAP and the successor to the single-register JTAG debug block.
- Provides the full 16-state TAP controller, an instruction register, and four data registers: BYPASS, IDCODE, DEBUG (DR_WIDTH bits) and HALT_CTRL.
- Sits between the board JTAG pins and the CPU debug interface. It drives halt_cpu and debug_reg to the core and samples cpu_halted as a status input.

Parameters:
- IR_WIDTH, 4, instruction register width; minimum 2.
- DR_WIDTH, 8, width of the DEBUG data register and the debug_reg output.
- IDCODE_VAL, 32'h1DA5_C001, value captured by IDCODE; bit 0 must be 1.

Ports:
- tck, input, 1, test clock; the only clock. All state changes on posedge, except tdo on negedge.
- trst_n, input, 1, asynchronous active-low reset.
- tms, input, 1, test mode select, sampled on posedge tck.
- tdi, input, 1, test data in, sampled on posedge tck.
- tdo, output, 1, test data out, updated on negedge tck.
- tdo_en, output, 1, high while the TAP is in Shift-IR or Shift-DR, updated on negedge tck.
- cpu_halted, input, 1, halt acknowledge from the CPU; captured into HALT_CTRL.
- halt_cpu, output, 1, halt request to the CPU.
- debug_reg, output, DR_WIDTH, debug value last written through JTAG.
- tap_state, output, 4, current TAP state encoding, for visibility and checking.

Behaviour:
- Reset: trst_n low forces, asynchronously:
  - TAP state to Test-Logic-Reset (TLR).
  - ir to IDCODE.
  - debug_reg, halt_cpu, tdo and tdo_en to 0.
  - all shift registers to 0.
- State encoding (tap_state): TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PauseDR=6, Ex2DR=7, UpdDR=8, SelIR=9, CapIR=10, ShIR=11, Ex1IR=12, PauseIR=13, Ex2IR=14, UpdIR=15.
- Transitions follow standard 1149.1 on posedge tck using tms. From any state, five consecutive tms=1 reach TLR.
- TLR entered by TMS (not trst_n): ir is set to IDCODE. debug_reg and halt_cpu are retained, so a debugger can reset the TAP without releasing the CPU.
- Instruction codes:
  - IDCODE = 1.
  - DEBUG = 2.
  - HALT_CTRL = 3.
  - BYPASS = all ones.
  - Any other code selects BYPASS.
- CapIR: the IR shift register loads {0…0, 2'b01}.
- ShIR: shift right, tdi enters the MSB, the LSB goes to tdo.
- UpdIR: ir takes the shift register contents.
- Data registers, selected by the current ir:
  - BYPASS: 1 bit, captures 0.
  - IDCODE: 32 bits, captures IDCODE_VAL.
  - DEBUG: DR_WIDTH bits, captures the current debug_reg. On UpdDR, debug_reg takes the shifted value.
  - HALT_CTRL: 2 bits, captures {cpu_halted, halt_cpu}. On UpdDR, halt_cpu takes shift bit 0; bit 1 is ignored.
- All DRs shift LSB first: tdi enters the MSB of the selected register each ShDR cycle.
- Pause states and Exit states hold shift contents unchanged.
- tdo: on negedge tck, tdo takes the LSB of the active shift register while in ShIR/ShDR. Otherwise tdo is 0 and tdo_en is 0.
- Shift-length boundaries:
  - A shift longer than the register width pushes bits through, so the update value is the last width bits shifted in.
  - A shorter shift leaves the upper captured bits shifted down.
- No update occurs unless UpdIR/UpdDR is actually visited. Exiting through Ex1→UpdDR commits the shifted value.
- trst_n asserted mid-shift aborts immediately; no partial update is applied to debug_reg or halt_cpu (both go to 0 per reset).
- Outputs debug_reg and halt_cpu change only on posedge tck in UpdDR, or on reset.

Test Plan:
- Assert trst_n low, then release; clock 3 cycles with tms=0 → tap_state=1 (RTI), ir=IDCODE, halt_cpu=0, debug_reg=0, tdo_en=0.
- From RTI, go to ShDR without loading IR; shift 32 bits → tdo stream LSB first equals 32'h1DA5_C001; tdo_en=1 only during ShDR.
- Load IR=2 (DEBUG) and shift 8'hA5 LSB first; pass through UpdDR → debug_reg=8'hA5. Then capture/shift 8 zeros → tdo returns 8'hA5 and debug_reg=8'h00.
- Load IR=3; shift 2'b01 with UpdDR → halt_cpu=1. Drive cpu_halted=1; capture/shift → tdo yields bit0=1 then bit1=1. Then hold tms=1 for 5 cycles → TLR, halt_cpu still 1, ir=IDCODE.
- Load IR=4'hF and shift 1,0,1,1 → tdo delayed by one bit (0,1,0,1). Load undefined IR=4'h7 → same bypass behaviour.
- In DEBUG, shift 4 of 8 bits of 8'hFF after debug_reg=8'h3C, then assert trst_n → debug_reg=0, tap_state=0, no update. Separately, a 12-bit shift of 12'hABC → debug_reg=8'hAB.
